stage2_meeting: RTL and testbench
=================================

# stage2_meeting

Sequential second-round evaluator of the graduation-exam pipeline. Gated by the stage-1 verdict, it collects a fixed number of weekly advisor-meeting reports over a valid/ready handshake. It then produces the registered `pass2` verdict and the 2-bit `bonus2` grade that the stage-3 judge consumes. Results are held stable until the next evaluation completes.

## Interface
Parameters:
- `NUM_WEEKS`, default 8: weekly reports collected per evaluation (2..15).
- `PASS_MIN`, default 5: minimum attended weeks required to pass (1..NUM_WEEKS).

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: begin an evaluation; sampled only in IDLE.
- `pass1`  in  1: stage-1 verdict, sampled with `start`.
- `luck2`  in  3: luck value, sampled with `start`.
- `wk_valid`  in  1: a weekly report is presented.
- `wk_ready`  out  1: block accepts reports; high only in COLLECT.
- `wk_attend`  in  1: 1 means the meeting was attended.
- `wk_progress`  in  3: progress score 0..7; ignored when `wk_attend`=0.
- `busy`  out  1: state ≠ IDLE.
- `done`  out  1: one-cycle pulse when `pass2` and `bonus2` update.
- `pass2`  out  1: registered verdict.
- `bonus2`  out  2: registered grade 0..3.

## Operation
- FSM states: IDLE, COLLECT, JUDGE.
- IDLE with `start`=1:
  - Latch `luck2`.
  - Clear `att_cnt`, `wk_cnt`, `prog_sum` and `abs_run`.
  - Go to COLLECT if `pass1`=1; otherwise go to JUDGE with a forced-fail flag set.
- COLLECT: a handshake is `wk_valid & wk_ready`. On each handshake:
  - Increment `wk_cnt`.
  - If `wk_attend`=1: increment `att_cnt`, add `wk_progress` to `prog_sum`, and clear `abs_run`.
  - If `wk_attend`=0: increment `abs_run`.
  - Go to JUDGE after the handshake that makes `wk_cnt`=NUM_WEEKS.
- Register widths:
  - `wk_cnt` and `att_cnt`: 4 bits.
  - `prog_sum`: 7 bits (max 7×15=105, no overflow).
  - `abs_run`: 2 bits, saturating at 3.
- JUDGE lasts one cycle, then returns to IDLE. It loads the following, all registered:
  - `pass2` = !forced_fail & !dropout & (`att_cnt` ≥ PASS_MIN).
  - Base grade: 3 if `prog_sum` ≥ 6·NUM_WEEKS; else 2 if ≥ 4·NUM_WEEKS; else 1 if ≥ 2·NUM_WEEKS; else 0.
  - If latched `luck2`=3'b111, the base grade is incremented, saturating at 3.
  - `bonus2` = `pass2` ? grade : 0.
  - `done` = 1.
- `start` in COLLECT or JUDGE is ignored.
- `wk_valid` outside COLLECT is ignored (`wk_ready`=0).

## Timing
- Reset values: state IDLE; `busy`, `done`, `wk_ready`, `pass2` = 0; `bonus2` = 2'd0; all counters 0.
- `rst` mid-evaluation aborts on the next edge with the same values; the partial evaluation is discarded.
- `start` accepted in cycle t: `busy` and `wk_ready` are high from t+1.
- Last accepted handshake in cycle k: JUDGE in k+1; `done`, `pass2` and `bonus2` valid in k+2, with `busy`=0 in that same cycle.
- `pass1`=0 at start: JUDGE in t+1, `done` in t+2, `pass2`=0, `bonus2`=0; `wk_ready` is never asserted.
- Minimum evaluation (no `wk_valid` gaps): `done` at t+NUM_WEEKS+2.
- A new `start` is accepted in the same cycle `done` is high, since the state is IDLE.
- `pass2` and `bonus2` hold their values between `done` pulses; they are not cleared at `start`.
- `wk_valid` gaps stall collection indefinitely; no timeout.

## Configuration
- `STAGE2_DROPOUT_EN` defined:
  - The handshake that makes `abs_run` reach 3 (third consecutive absence) sets dropout and moves to JUDGE immediately, even if `wk_cnt` < NUM_WEEKS.
  - JUDGE then forces `pass2`=0 and `bonus2`=0.
- Undefined:
  - `abs_run` and dropout logic are absent; dropout is constant 0.
  - Collection always runs to NUM_WEEKS; absences only reduce `att_cnt`.

## Test plan
Defaults NUM_WEEKS=8, PASS_MIN=5.
- `pass1`=1, `luck2`=0, 8 back-to-back weeks with attend=1 and progress=6 (`prog_sum`=48) -> `done` at t+10, `pass2`=1, `bonus2`=3.
- `pass1`=0 -> `wk_ready` stays 0; `done` at t+2 with `pass2`=0, `bonus2`=0.
- Attend pattern 1,0,1,0,1,0,1,1 with progress 4 on attended weeks (`prog_sum`=20), `luck2`=3'b111 -> `pass2`=1; base grade 1 raised to `bonus2`=2.
- Attend pattern 1,0,0,0,…:
  - With `STAGE2_DROPOUT_EN`: `done` two cycles after the 4th handshake; `pass2`=0; `wk_ready` drops after the 4th handshake.
  - Without it: all 8 weeks are collected.
- 4 attended weeks at progress 7 plus 4 absences (non-consecutive) -> `pass2`=0, `bonus2`=0.
- Random `wk_valid` gaps, then `rst` after 3 handshakes -> next cycle `busy`=0 and all outputs 0. A fresh `start` then completes normally, with no carry-over from the aborted run.

Source files
------------

// File: rtl/stage2_meeting_if.sv
// Weekly advisor-report handshake between the report source (master) and stage2_meeting (slave).
interface stage2_meeting_if;
  logic       wk_valid;
  logic       wk_ready;
  logic       wk_attend;
  logic [2:0] wk_progress;

  modport master (output wk_valid, wk_attend, wk_progress, input wk_ready);
  modport slave  (input wk_valid, wk_attend, wk_progress, output wk_ready);
endinterface

// File: rtl/stage2_meeting.sv
// stage2_meeting: second-round evaluator that collects NUM_WEEKS advisor reports and grades them.
// Optional macro STAGE2_DROPOUT_EN: a third consecutive absence ends the evaluation as a fail.
module stage2_meeting #(
  parameter int unsigned NUM_WEEKS = 8,
  parameter int unsigned PASS_MIN  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            pass1,
  input  logic [2:0]      luck2,
  stage2_meeting_if.slave wk,
  output logic            busy,
  output logic            done,
  output logic            pass2,
  output logic [1:0]      bonus2
);

  typedef enum logic [1:0] {IDLE, COLLECT, JUDGE} state_t;

  localparam logic [3:0] WEEKS_C = 4'(NUM_WEEKS);
  localparam logic [3:0] PMIN_C  = 4'(PASS_MIN);
  localparam logic [6:0] TH3     = 7'(6 * NUM_WEEKS);
  localparam logic [6:0] TH2     = 7'(4 * NUM_WEEKS);
  localparam logic [6:0] TH1     = 7'(2 * NUM_WEEKS);

  state_t     state_q, state_d;
  logic [3:0] wk_cnt_q, wk_cnt_d;
  logic [3:0] att_cnt_q, att_cnt_d;
  logic [6:0] prog_sum_q, prog_sum_d;
  logic [2:0] luck_q, luck_d;
  logic       ff_q, ff_d;
  logic       done_q, done_d;
  logic       pass2_q, pass2_d;
  logic [1:0] bonus2_q, bonus2_d;
  logic [1:0] base_grade, grade;
  logic       hs, dropout;

`ifdef STAGE2_DROPOUT_EN
  logic [1:0] abs_run_q, abs_run_d;
  logic       drop_q, drop_d;
  assign dropout = drop_q;
`else
  assign dropout = 1'b0;
`endif

  assign hs = wk.wk_valid & wk.wk_ready;

  always_comb begin
    if (prog_sum_q >= TH3)      base_grade = 2'd3;
    else if (prog_sum_q >= TH2) base_grade = 2'd2;
    else if (prog_sum_q >= TH1) base_grade = 2'd1;
    else                        base_grade = 2'd0;
    grade = base_grade;
    if (luck_q == 3'b111 && base_grade != 2'd3) grade = base_grade + 2'd1;
  end

  always_comb begin
    state_d    = state_q;
    wk_cnt_d   = wk_cnt_q;
    att_cnt_d  = att_cnt_q;
    prog_sum_d = prog_sum_q;
    luck_d     = luck_q;
    ff_d       = ff_q;
    done_d     = 1'b0;
    pass2_d    = pass2_q;
    bonus2_d   = bonus2_q;
`ifdef STAGE2_DROPOUT_EN
    abs_run_d  = abs_run_q;
    drop_d     = drop_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          luck_d     = luck2;
          wk_cnt_d   = '0;
          att_cnt_d  = '0;
          prog_sum_d = '0;
          ff_d       = ~pass1;
`ifdef STAGE2_DROPOUT_EN
          abs_run_d  = '0;
          drop_d     = 1'b0;
`endif
          state_d    = pass1 ? COLLECT : JUDGE;
        end
      end
      COLLECT: begin
        if (hs) begin
          wk_cnt_d = wk_cnt_q + 4'd1;
          if (wk.wk_attend) begin
            att_cnt_d  = att_cnt_q + 4'd1;
            prog_sum_d = prog_sum_q + {4'b0000, wk.wk_progress};
          end
          if (wk_cnt_d == WEEKS_C) state_d = JUDGE;
`ifdef STAGE2_DROPOUT_EN
          if (wk.wk_attend) begin
            abs_run_d = '0;
          end else begin
            if (abs_run_q != 2'd3) abs_run_d = abs_run_q + 2'd1;
            // The third consecutive absence ends collection early.
            if (abs_run_q == 2'd2) begin
              drop_d  = 1'b1;
              state_d = JUDGE;
            end
          end
`endif
        end
      end
      JUDGE: begin
        pass2_d  = ~ff_q & ~dropout & (att_cnt_q >= PMIN_C);
        bonus2_d = pass2_d ? grade : '0;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wk_cnt_q   <= '0;
      att_cnt_q  <= '0;
      prog_sum_q <= '0;
      luck_q     <= '0;
      ff_q       <= 1'b0;
      done_q     <= 1'b0;
      pass2_q    <= 1'b0;
      bonus2_q   <= '0;
`ifdef STAGE2_DROPOUT_EN
      abs_run_q  <= '0;
      drop_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wk_cnt_q   <= wk_cnt_d;
      att_cnt_q  <= att_cnt_d;
      prog_sum_q <= prog_sum_d;
      luck_q     <= luck_d;
      ff_q       <= ff_d;
      done_q     <= done_d;
      pass2_q    <= pass2_d;
      bonus2_q   <= bonus2_d;
`ifdef STAGE2_DROPOUT_EN
      abs_run_q  <= abs_run_d;
      drop_q     <= drop_d;
`endif
    end
  end

  assign busy        = (state_q != IDLE);
  assign wk.wk_ready = (state_q == COLLECT);
  assign done        = done_q;
  assign pass2       = pass2_q;
  assign bonus2      = bonus2_q;

endmodule

// File: tb/tb_stage2_meeting.sv
// Self-checking bench for stage2_meeting: vector table plus scoreboard popped on each done pulse.
module tb_stage2_meeting;

  logic       clk = 1'b0;
  logic       rst, start, pass1;
  logic [2:0] luck2;
  logic       busy, done, pass2;
  logic [1:0] bonus2;

  stage2_meeting_if wk_if ();

  stage2_meeting #(.NUM_WEEKS(8), .PASS_MIN(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .pass1  (pass1),
    .luck2  (luck2),
    .wk     (wk_if),
    .busy   (busy),
    .done   (done),
    .pass2  (pass2),
    .bonus2 (bonus2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pass1;
    logic [2:0]  luck;
    logic [7:0]  att;
    logic [2:0]  prog;
    logic        gaps;
    logic        exp_pass;
    logic [1:0]  exp_bonus;
    int unsigned exp_hs;
  } vec_t;

  typedef struct {
    logic       p;
    logic [1:0] b;
  } res_t;

  res_t sbq[$];
  res_t mr;
  vec_t vecs[10];
  vec_t fresh;
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        check("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        mr = sbq.pop_front();
        check("sb_pass2", pass2, mr.p);
        check("sb_bonus2", bonus2, mr.b);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    wk_if.wk_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sbq.delete();
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int unsigned hs = 0;
    int unsigned budget = 0;
    res_t r;
    @(negedge clk);
    start = 1'b1; pass1 = v.pass1; luck2 = v.luck;
    r.p = v.exp_pass; r.b = v.exp_bonus;
    sbq.push_back(r);
    @(negedge clk);
    start = 1'b0; pass1 = 1'b0; luck2 = 3'd0;
    check({nm, "_busy_t1"}, busy, 1);
    check({nm, "_ready_t1"}, wk_if.wk_ready, v.pass1);
    while (hs < v.exp_hs && budget < 200) begin
      wk_if.wk_valid    = v.gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      wk_if.wk_attend   = v.att[hs];
      wk_if.wk_progress = v.att[hs] ? v.prog : 3'($urandom_range(0, 7));
      // start/luck noise during collection must be ignored
      start = v.gaps; pass1 = 1'b0; luck2 = ~v.luck;
      if (wk_if.wk_valid && wk_if.wk_ready) hs++;
      budget++;
      @(negedge clk);
    end
    start = 1'b0; luck2 = 3'd0;
    wk_if.wk_valid = ~v.pass1;
    if (budget >= 200) begin
      check({nm, "_handshake_timeout"}, hs, v.exp_hs);
      do_reset();
      return;
    end
    check({nm, "_ready_judge"}, wk_if.wk_ready, 0);
    check({nm, "_done_judge"}, done, 0);
    check({nm, "_busy_judge"}, busy, 1);
    @(negedge clk);
    wk_if.wk_valid = 1'b0;
    check({nm, "_done_pulse"}, done, 1);
    check({nm, "_busy_done"}, busy, 0);
    @(negedge clk);
    check({nm, "_done_drop"}, done, 0);
    check({nm, "_pass2_hold"}, pass2, v.exp_pass);
    check({nm, "_bonus2_hold"}, bonus2, v.exp_bonus);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned hs;
    int unsigned budget;
    res_t r;

    vecs[0] = '{1'b1, 3'd0, 8'hFF, 3'd6, 1'b0, 1'b1, 2'd3, 8};
    vecs[1] = '{1'b0, 3'd7, 8'hFF, 3'd7, 1'b0, 1'b0, 2'd0, 0};
    vecs[2] = '{1'b1, 3'd7, 8'hD5, 3'd4, 1'b0, 1'b1, 2'd2, 8};
`ifdef STAGE2_DROPOUT_EN
    vecs[3] = '{1'b1, 3'd0, 8'hF1, 3'd7, 1'b1, 1'b0, 2'd0, 4};
`else
    vecs[3] = '{1'b1, 3'd0, 8'hF1, 3'd7, 1'b1, 1'b1, 2'd2, 8};
`endif
    vecs[4] = '{1'b1, 3'd0, 8'h55, 3'd7, 1'b1, 1'b0, 2'd0, 8};
    vecs[5] = '{1'b1, 3'd0, 8'hFF, 3'd2, 1'b1, 1'b1, 2'd1, 8};
    vecs[6] = '{1'b1, 3'd7, 8'hFF, 3'd7, 1'b0, 1'b1, 2'd3, 8};
    vecs[7] = '{1'b1, 3'd6, 8'hFF, 3'd4, 1'b0, 1'b1, 2'd2, 8};
    vecs[8] = '{1'b1, 3'd0, 8'hDC, 3'd5, 1'b1, 1'b1, 2'd1, 8};
    vecs[9] = '{1'b1, 3'd0, 8'hFF, 3'd1, 1'b0, 1'b1, 2'd0, 8};
    fresh   = '{1'b1, 3'd0, 8'hFF, 3'd2, 1'b1, 1'b1, 2'd1, 8};

    rst = 1'b1; start = 1'b0; pass1 = 1'b0; luck2 = 3'd0;
    wk_if.wk_valid = 1'b0; wk_if.wk_attend = 1'b0; wk_if.wk_progress = 3'd0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", wk_if.wk_ready, 0);
    check("rst_pass2", pass2, 0);
    check("rst_bonus2", bonus2, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Back-to-back: a start in the done cycle is accepted.
    @(negedge clk);
    start = 1'b1; pass1 = 1'b0;
    r.p = 1'b0; r.b = 2'd0; sbq.push_back(r);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("b2b_done1", done, 1);
    start = 1'b1; pass1 = 1'b0;
    sbq.push_back(r);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_done_gap", done, 0);
    @(negedge clk);
    check("b2b_done2", done, 1);
    @(negedge clk);

    // Prime pass2=1 so the abort check sees outputs actually cleared.
    run_vec(vecs[6], "prime");

    @(negedge clk);
    start = 1'b1; pass1 = 1'b1; luck2 = 3'd7;
    @(negedge clk);
    start = 1'b0; pass1 = 1'b0; luck2 = 3'd0;
    hs = 0; budget = 0;
    while (hs < 3 && budget < 200) begin
      wk_if.wk_valid = ($urandom_range(0, 1) != 0);
      wk_if.wk_attend = 1'b1;
      wk_if.wk_progress = 3'd7;
      if (wk_if.wk_valid && wk_if.wk_ready) hs++;
      budget++;
      @(negedge clk);
    end
    check("abort_hs_count", hs, 3);
    rst = 1'b1;
    wk_if.wk_valid = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_ready", wk_if.wk_ready, 0);
    check("abort_done", done, 0);
    check("abort_pass2", pass2, 0);
    check("abort_bonus2", bonus2, 0);
    rst = 1'b0;
    sbq.delete();
    wk_if.wk_valid = 1'b1;
    wk_if.wk_attend = 1'b1;
    @(negedge clk);
    run_vec(fresh, "fresh");

    repeat (3) @(negedge clk);
    check("sb_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
